// File: rtl/ram_access_ctrl_pkg.sv
// Shared types for the RAM access controller.
// FSM state encoding and request address width.
package ram_access_ctrl_pkg;

    localparam int REQ_AW = 16;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RESP,
        ST_RESP_ERR
    } state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear address sequencer.
// AW+1 bit counter; the top bit flags that every address has been issued.
module ram_clear_seq #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    output logic [AW-1:0] o_addr,
    output logic          o_done
);

    logic [AW:0] r_ctr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctr <= '0;
        end else if (i_start && !r_ctr[AW]) begin
            r_ctr <= r_ctr + 1'b1;
        end
    end

    assign o_addr = r_ctr[AW-1:0];
    assign o_done = r_ctr[AW];

endmodule

// File: rtl/ram_access_ctrl.sv
// Requester-side controller for a single-port synchronous RAM.
// Zero-fills the RAM after reset, then serves one load/store at a time.
module ram_access_ctrl #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int CLEAR_EN = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [15:0]   req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          init_done,
    output logic          ram_we,
    output logic [15:0]   ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    import ram_access_ctrl_pkg::*;

    localparam logic [1:0] LP_LAT = 2'(RD_LAT);

    state_t          r_state;
    logic [1:0]      r_wait;
    logic            w_clr_start;
    logic [AW-1:0]   w_clr_addr;
    logic            w_clr_done;
    logic            w_oor;
    logic            w_hs;

    assign w_clr_start = (r_state == ST_CLEAR) && (CLEAR_EN != 0);
    assign w_oor       = (req_addr >> AW) != 16'd0;
    assign w_hs        = req_valid && req_ready;

    ram_clear_seq #(
        .AW(AW)
    ) u_clear (
        .clk    (clk),
        .rst_n  (reset_n),
        .i_start(w_clr_start),
        .o_addr (w_clr_addr),
        .o_done (w_clr_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_CLEAR;
            r_wait    <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            init_done <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            unique case (r_state)
                ST_CLEAR: begin
                    if (CLEAR_EN == 0 || w_clr_done) begin
                        r_state   <= ST_IDLE;
                        ram_we    <= 1'b0;
                        ram_addr  <= '0;
                        ram_din   <= '0;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end else begin
                        ram_we   <= 1'b1;
                        ram_addr <= 16'(w_clr_addr);
                        ram_din  <= '0;
                    end
                end
                ST_IDLE: begin
                    if (w_hs) begin
                        req_ready <= 1'b0;
                        if (w_oor) begin
                            r_state   <= ST_RESP_ERR;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (req_we) begin
                            r_state   <= ST_WRITE;
                            ram_we    <= 1'b1;
                            ram_addr  <= 16'(req_addr[AW-1:0]);
                            ram_din   <= req_wdata;
                            rsp_valid <= 1'b1;
                        end else begin
                            r_state  <= ST_READ;
                            ram_addr <= 16'(req_addr[AW-1:0]);
                            r_wait   <= '0;
                        end
                    end
                end
                ST_READ: begin
                    // dout for the held address is valid in the last wait cycle
                    if (r_wait == LP_LAT) begin
                        r_state   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= ram_dout;
                        ram_addr  <= '0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_WRITE, ST_RESP, ST_RESP_ERR: begin
                    r_state   <= ST_IDLE;
                    ram_we    <= 1'b0;
                    ram_addr  <= '0;
                    ram_din   <= '0;
                    req_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule
